// File: rtl/life_pkg.sv
// Shared types and helpers for the Life row engine: FSM state encoding, Conway rule masks
// and the neighbour counter used by every cell.
package life_pkg;

  typedef enum logic [1:0] {
    S_EDIT,
    S_IDLE,
    S_EVAL,
    S_COMMIT
  } life_state_t;

  localparam logic [8:0] CONWAY_BIRTH   = 9'h008;
  localparam logic [8:0] CONWAY_SURVIVE = 9'h00C;

  function automatic logic [3:0] nbr_count(input logic [7:0] nbr);
    logic [3:0] cnt;
    cnt = '0;
    for (int k = 0; k < 8; k++) begin
      cnt = cnt + {3'b000, nbr[k]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/life_cell_next.sv
// Combinational next-state of one Life-like cell from its eight neighbours and the
// programmable birth/survive masks.
module life_cell_next
  import life_pkg::*;
(
  input  logic [7:0] nbr_i,
  input  logic       alive_i,
  input  logic [8:0] birth_mask_i,
  input  logic [8:0] survive_mask_i,
  output logic       next_o
);

  logic [3:0] cnt;

  always_comb begin
    cnt    = nbr_count(nbr_i);
    next_o = alive_i ? survive_mask_i[cnt] : birth_mask_i[cnt];
  end

endmodule

// File: rtl/life_row_engine.sv
// One row of WIDTH Life-like cells with edit cursor, step handshake and population summary.
// Define LIFE_AGE_EN to add the per-cell age output cell_age.
module life_row_engine
  import life_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned WRAP  = 1,
  parameter int unsigned GEN_W = 16,
  parameter int unsigned AGE_W = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       game_state,
  input  logic                       step,
  input  logic [8:0]                 birth_mask,
  input  logic [8:0]                 survive_mask,
  input  logic [WIDTH-1:0]           row_above,
  input  logic [WIDTH-1:0]           row_below,
  input  logic [$clog2(WIDTH)-1:0]   cursor,
  input  logic                       user_toggle,
  output logic [WIDTH-1:0]           row_state,
  output logic                       busy,
  output logic                       step_done,
  output logic [GEN_W-1:0]           generation,
  output logic [$clog2(WIDTH+1)-1:0] alive_count,
  output logic                       stable
`ifdef LIFE_AGE_EN
  ,
  output logic [WIDTH*AGE_W-1:0]     cell_age
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned AW = $clog2(WIDTH+1);

  life_state_t      state_q, state_d;
  logic [WIDTH-1:0] row_q, row_d, next_q, next_d, cell_next;
  logic [WIDTH-1:0] cur_sel, flip_mask;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic [AW-1:0]    alive_q, alive_d;
  logic             key_q, key_prev_q, edit_flip;
  logic             step_done_q, step_done_d, stable_q, stable_d;

  // Edge-extended rows: slot 0 is column -1, slot WIDTH+1 is column WIDTH.
  logic [WIDTH+1:0] above_ext, below_ext, row_ext;

  always_comb begin
    above_ext = {(WRAP != 0) ? row_above[0] : 1'b0, row_above,
                 (WRAP != 0) ? row_above[WIDTH-1] : 1'b0};
    below_ext = {(WRAP != 0) ? row_below[0] : 1'b0, row_below,
                 (WRAP != 0) ? row_below[WIDTH-1] : 1'b0};
    row_ext   = {(WRAP != 0) ? row_q[0] : 1'b0, row_q,
                 (WRAP != 0) ? row_q[WIDTH-1] : 1'b0};
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    life_cell_next u_cell (
      .nbr_i          ({above_ext[i+2:i], below_ext[i+2:i], row_ext[i+2], row_ext[i]}),
      .alive_i        (row_q[i]),
      .birth_mask_i   (birth_mask),
      .survive_mask_i (survive_mask),
      .next_o         (cell_next[i])
    );
  end

  // Decoding the cursor one-hot makes out-of-range columns select nothing.
  always_comb begin
    edit_flip = (state_q == S_EDIT) && key_q && !key_prev_q;
    for (int i = 0; i < WIDTH; i++) begin
      cur_sel[i] = (cursor == CW'(i));
    end
    flip_mask = cur_sel & {WIDTH{edit_flip}};
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    next_d      = next_q;
    gen_d       = gen_q;
    stable_d    = stable_q;
    step_done_d = 1'b0;
    case (state_q)
      S_EDIT: begin
        if (flip_mask != '0) begin
          row_d    = row_q ^ flip_mask;
          stable_d = 1'b0;
        end
        if (game_state) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!game_state)  state_d = S_EDIT;
        else if (step)    state_d = S_EVAL;
      end
      S_EVAL: begin
        next_d  = cell_next;
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        row_d       = next_q;
        step_done_d = 1'b1;
        gen_d       = gen_q + GEN_W'(1);
        stable_d    = (next_q == row_q);
        state_d     = game_state ? S_IDLE : S_EDIT;
      end
      default: state_d = S_EDIT;
    endcase
  end

  always_comb begin
    alive_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      alive_d = alive_d + AW'(row_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EDIT;
      row_q       <= '0;
      next_q      <= '0;
      gen_q       <= '0;
      alive_q     <= '0;
      stable_q    <= 1'b0;
      step_done_q <= 1'b0;
      key_q       <= 1'b0;
      key_prev_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      next_q      <= next_d;
      gen_q       <= gen_d;
      alive_q     <= alive_d;
      stable_q    <= stable_d;
      step_done_q <= step_done_d;
      key_q       <= user_toggle;
      key_prev_q  <= key_q;
    end
  end

`ifdef LIFE_AGE_EN
  logic [WIDTH-1:0][AGE_W-1:0] age_q, age_d;

  always_comb begin
    age_d = age_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (flip_mask[i]) begin
        age_d[i] = row_q[i] ? '0 : AGE_W'(1);
      end else if (state_q == S_COMMIT) begin
        if (!next_q[i])            age_d[i] = '0;
        else if (!row_q[i])        age_d[i] = AGE_W'(1);
        else if (age_q[i] != '1)   age_d[i] = age_q[i] + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) age_q <= '0;
    else       age_q <= age_d;
  end

  assign cell_age = age_q;
`endif

  assign row_state   = row_q;
  assign busy        = (state_q == S_EVAL) || (state_q == S_COMMIT);
  assign step_done   = step_done_q;
  assign generation  = gen_q;
  assign alive_count = alive_q;
  assign stable      = stable_q;

endmodule
